// File: rtl/bf_pipe_pkg.sv
// Shared types and sizing helpers for the bilateral-filter pipeline flow-control blocks.
package bf_pipe_pkg;

    typedef struct packed {
        logic acc;
        logic pop;
        logic capture;
    } handshake_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A depth-1 FIFO still needs a 1-bit pointer to keep vector ranges legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Register-based output FIFO with wrap-around pointers that need not be a power of two.
module sync_fifo_ctrl
    import bf_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  doRd;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign doRd    = rd_en & ~empty;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_data = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wr_en) wrPtr_d = nextPtr(wrPtr_q);
            if (doRd)  rdPtr_d = nextPtr(rdPtr_q);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(doRd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem_q[wrPtr_q] <= wr_data;
    end

endmodule

// File: rtl/pipeline_credit_ctrl.sv
// Credit-based valid/ready wrapper around a fixed-latency, non-stallable datapath.
module pipeline_credit_ctrl
    import bf_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic [DATA_WIDTH-1:0]            pipe_in,
    input  logic [DATA_WIDTH-1:0]            pipe_out,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [cnt_w(FIFO_DEPTH)-1:0]     reserved
);

    localparam int CNT_W = cnt_w(FIFO_DEPTH);

    if (LATENCY < 1) begin : gBadLatency
        $error("pipeline_credit_ctrl: LATENCY must be >= 1");
    end
    if (FIFO_DEPTH < 1) begin : gBadDepth
        $error("pipeline_credit_ctrl: FIFO_DEPTH must be >= 1");
    end

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]   reserved_q, reserved_d;
    handshake_t         hs;
    logic               fifoEmpty;
    logic               fifoFull;

    // Credit is taken from registered state only, so s_ready never sees m_ready or s_valid.
    assign s_ready  = ~clr & (reserved_q < CNT_W'(FIFO_DEPTH));
    assign m_valid  = ~fifoEmpty;
    assign pipe_in  = s_data;
    assign reserved = reserved_q;

    always_comb begin
        hs         = '0;
        hs.acc     = s_valid & s_ready;
        hs.pop     = m_valid & m_ready;
        hs.capture = vld_q[LATENCY-1];
    end

    always_comb begin
        vld_d      = '0;
        reserved_d = '0;
        if (!clr) begin
            vld_d[0] = hs.acc;
            for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
            reserved_d = reserved_q + CNT_W'(hs.acc) - CNT_W'(hs.pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            reserved_q <= '0;
        end else begin
            vld_q      <= vld_d;
            reserved_q <= reserved_d;
        end
    end

    sync_fifo_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (hs.capture),
        .wr_data (pipe_out),
        .rd_en   (hs.pop),
        .rd_data (m_data),
        .empty   (fifoEmpty),
        .full    (fifoFull)
    );

    // Capture is bounded by credit, so a write into a full FIFO means the accounting broke.
    noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(hs.capture && fifoFull && !clr));

endmodule

// File: tb/tb_pipeline_credit_ctrl.sv
// Self-checking bench for pipeline_credit_ctrl: directed tables plus randomized traffic against a queue model.
module tb_pipeline_credit_ctrl;
    import bf_pipe_pkg::*;

    localparam int DW     = 16;
    localparam int LAT    = 4;
    localparam int DEPTH  = 8;
    localparam int LAT1   = 1;
    localparam int DEPTH1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                        clr, sValid, sReady, mValid, mReady;
    logic [DW-1:0]               sData, pipeIn, pipeOut, mData;
    logic [cnt_w(DEPTH)-1:0]     reserved;

    logic                        clr1, sValid1, sReady1, mValid1, mReady1;
    logic [DW-1:0]               sData1, pipeIn1, pipeOut1, mData1;
    logic [cnt_w(DEPTH1)-1:0]    reserved1;

    pipeline_credit_ctrl #(.DATA_WIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(sValid), .s_ready(sReady), .s_data(sData),
        .pipe_in(pipeIn), .pipe_out(pipeOut), .m_valid(mValid), .m_ready(mReady), .m_data(mData),
        .reserved(reserved)
    );

    pipeline_credit_ctrl #(.DATA_WIDTH(DW), .LATENCY(LAT1), .FIFO_DEPTH(DEPTH1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .s_valid(sValid1), .s_ready(sReady1), .s_data(sData1),
        .pipe_in(pipeIn1), .pipe_out(pipeOut1), .m_valid(mValid1), .m_ready(mReady1), .m_data(mData1),
        .reserved(reserved1)
    );

    // Free-running identity datapaths standing in for pipeline_shift instances.
    logic [DW-1:0] dpStage [LAT];
    logic [DW-1:0] dpStage1;
    always @(posedge clk) begin
        dpStage[0] <= pipeIn;
        for (int i = 1; i < LAT; i++) dpStage[i] <= dpStage[i-1];
        dpStage1 <= pipeIn1;
    end
    assign pipeOut  = dpStage[LAT-1];
    assign pipeOut1 = dpStage1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } flight_t;

    typedef struct {
        logic          sv;
        logic          mr;
        logic [DW-1:0] d;
        logic          expSR;
        logic          expMV;
        int            expRes;
        logic [DW-1:0] expMD;
    } vec_t;

    flight_t       flightQ[$];
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] outLog[$];
    int            cyc;
    int            checks;
    int            errors;
    vec_t          fillVec[14];
    vec_t          l1Vec[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int modelRes();
        return flightQ.size() + fifoQ.size();
    endfunction

    task automatic modelReset();
        flightQ.delete();
        fifoQ.delete();
    endtask

    task automatic applyStimulus(input logic sv, input logic [DW-1:0] d, input logic mr, input logic c);
        sValid = sv;
        sData  = d;
        mReady = mr;
        clr    = c;
        #1;
    endtask

    task automatic checkOutput();
        logic expSR;
        expSR = !clr && (modelRes() < DEPTH);
        check("s_ready", int'(sReady), int'(expSR));
        check("m_valid", int'(mValid), int'(fifoQ.size() != 0));
        check("reserved", int'(reserved), modelRes());
        check("reserved_range", int'(int'(reserved) <= DEPTH), 1);
        if (fifoQ.size() != 0) check("m_data", int'(mData), int'(fifoQ[0]));
    endtask

    // Advances one clock edge and updates the model: pop head, land due tokens, launch the new one.
    task automatic advance();
        logic          acc, pop, clrNow;
        logic [DW-1:0] accData;
        flight_t       f;
        acc     = sValid && !clr && (modelRes() < DEPTH);
        pop     = (fifoQ.size() != 0) && mReady;
        clrNow  = clr;
        accData = sData;
        if (mValid && mReady && !clr) outLog.push_back(mData);
        @(posedge clk);
        if (clrNow) begin
            modelReset();
        end else begin
            if (pop) void'(fifoQ.pop_front());
            while (flightQ.size() > 0 && flightQ[0].due == cyc) begin
                fifoQ.push_back(flightQ[0].data);
                void'(flightQ.pop_front());
            end
            if (acc) begin
                f.data = accData;
                f.due  = cyc + LAT;
                flightQ.push_back(f);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic doCycle(input logic sv, input logic [DW-1:0] d, input logic mr, input logic c);
        applyStimulus(sv, d, mr, c);
        checkOutput();
        advance();
    endtask

    task automatic doReset();
        clr = 1'b0; sValid = 1'b0; mReady = 1'b0;
        clr1 = 1'b0; sValid1 = 1'b0; mReady1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int firstValid;
        int readyDrops;
        checks = 0; errors = 0; cyc = 0;
        clr = 1'b0; sValid = 1'b0; sData = '0; mReady = 1'b0;
        clr1 = 1'b0; sValid1 = 1'b0; sData1 = '0; mReady1 = 1'b0;

        // m_ready held low until row 10; eight accepts fill the credit, then pops resume.
        fillVec[0]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 0, 16'h0000};
        fillVec[1]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1, 16'h0000};
        fillVec[2]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 2, 16'h0000};
        fillVec[3]  = '{1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 3, 16'h0000};
        fillVec[4]  = '{1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 4, 16'h0000};
        fillVec[5]  = '{1'b1, 1'b0, 16'h0006, 1'b1, 1'b1, 5, 16'h0001};
        fillVec[6]  = '{1'b1, 1'b0, 16'h0007, 1'b1, 1'b1, 6, 16'h0001};
        fillVec[7]  = '{1'b1, 1'b0, 16'h0008, 1'b1, 1'b1, 7, 16'h0001};
        fillVec[8]  = '{1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b1, 8, 16'h0001};
        fillVec[9]  = '{1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b1, 8, 16'h0001};
        fillVec[10] = '{1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1, 8, 16'h0001};
        fillVec[11] = '{1'b1, 1'b1, 16'h0009, 1'b1, 1'b1, 7, 16'h0002};
        fillVec[12] = '{1'b1, 1'b1, 16'h000A, 1'b1, 1'b1, 7, 16'h0003};
        fillVec[13] = '{1'b1, 1'b1, 16'h000B, 1'b1, 1'b1, 7, 16'h0004};

        // LATENCY=1, FIFO_DEPTH=2 with both sides always willing.
        l1Vec[0] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 0, 16'h0000};
        l1Vec[1] = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1, 16'h0000};
        l1Vec[2] = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 2, 16'h0001};
        l1Vec[3] = '{1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 1, 16'h0002};
        l1Vec[4] = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1, 16'h0000};
        l1Vec[5] = '{1'b1, 1'b1, 16'h0006, 1'b0, 1'b1, 2, 16'h0004};
        l1Vec[6] = '{1'b1, 1'b1, 16'h0007, 1'b1, 1'b1, 1, 16'h0005};
        l1Vec[7] = '{1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, 1, 16'h0000};

        doReset();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        check("reset_s_ready", int'(sReady), 1);
        check("reset_m_valid", int'(mValid), 0);
        check("reset_reserved", int'(reserved), 0);
        checkOutput();
        advance();

        $display("[TB] back-to-back burst");
        outLog.delete();
        firstValid = -1;
        readyDrops = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(k < 16 ? 1'b1 : 1'b0, 16'(k + 1), 1'b1, 1'b0);
            if (mValid && firstValid < 0) firstValid = k;
            if (k < 16 && !sReady) readyDrops++;
            checkOutput();
            advance();
        end
        check("first_valid_cycle", firstValid, 5);
        check("s_ready_drops", readyDrops, 0);
        check("burst_out_count", outLog.size(), 16);
        for (int i = 0; i < outLog.size(); i++) check("burst_order", int'(outLog[i]), i + 1);

        $display("[TB] credit fill table");
        doReset();
        outLog.delete();
        for (int r = 0; r < 14; r++) begin
            applyStimulus(fillVec[r].sv, fillVec[r].d, fillVec[r].mr, 1'b0);
            check("tbl_s_ready", int'(sReady), int'(fillVec[r].expSR));
            check("tbl_m_valid", int'(mValid), int'(fillVec[r].expMV));
            check("tbl_reserved", int'(reserved), fillVec[r].expRes);
            if (fillVec[r].expMV) check("tbl_m_data", int'(mData), int'(fillVec[r].expMD));
            checkOutput();
            advance();
        end
        for (int k = 0; k < 20; k++) doCycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("fill_out_count", outLog.size(), 11);
        for (int i = 0; i < outLog.size(); i++) check("fill_order", int'(outLog[i]), i + 1);

        $display("[TB] synchronous clear");
        doReset();
        outLog.delete();
        for (int k = 0; k < 5; k++) doCycle(1'b1, 16'(16'h00A1 + k), 1'b0, 1'b0);
        doCycle(1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b1);
        check("pre_clr_m_valid", int'(mValid), 1);
        check("pre_clr_reserved", int'(reserved), 5);
        check("clr_s_ready", int'(sReady), 0);
        checkOutput();
        advance();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        check("post_clr_m_valid", int'(mValid), 0);
        check("post_clr_reserved", int'(reserved), 0);
        checkOutput();
        advance();
        for (int k = 0; k < 12; k++) doCycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("clr_leak_count", outLog.size(), 0);

        $display("[TB] asynchronous reset mid-burst");
        doReset();
        for (int k = 0; k < 6; k++) doCycle(1'b1, 16'(16'h0200 + k), 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0206, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_s_ready", int'(sReady), 1);
        check("async_m_valid", int'(mValid), 0);
        check("async_reserved", int'(reserved), 0);
        sValid = 1'b0;
        mReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        outLog.delete();
        for (int k = 0; k < 10; k++) doCycle(1'b1, 16'(16'h0300 + k), 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) doCycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("post_reset_count", outLog.size(), 10);
        for (int i = 0; i < outLog.size(); i++) check("post_reset_order", int'(outLog[i]), 16'h0300 + i);

        $display("[TB] random traffic");
        doReset();
        for (int k = 0; k < 2000; k++)
            doCycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 20; k++) doCycle(1'b0, 16'h0000, 1'b1, 1'b0);
        check("random_drained", int'(mValid), 0);

        $display("[TB] latency 1, depth 2");
        doReset();
        for (int r = 0; r < 8; r++) begin
            sValid1 = l1Vec[r].sv;
            sData1  = l1Vec[r].d;
            mReady1 = l1Vec[r].mr;
            #1;
            check("l1_s_ready", int'(sReady1), int'(l1Vec[r].expSR));
            check("l1_m_valid", int'(mValid1), int'(l1Vec[r].expMV));
            check("l1_reserved", int'(reserved1), l1Vec[r].expRes);
            if (l1Vec[r].expMV) check("l1_m_data", int'(mData1), int'(l1Vec[r].expMD));
            @(posedge clk);
            #1;
        end
        sValid1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
